alu_result_monitor: RTL and testbench

Output-side monitor for the 32-bit MIPS ALU emulation bench; the receiving counterpart to the stimulus BFM that issues operations into the ALU. For every issued operation it waits out the ALU's fixed capture delay and any ALU_Stall period (multiply/divide). It then captures Result, BZero, EXC_Ov, HI and LO, tags the capture with a sequence number, and buffers it in a FIFO. The HVL scoreboard drains the FIFO over a valid/ready handshake.

---
 rtl/alu_result_monitor_if.sv | 50 +++++
 rtl/alu_result_monitor.sv | 214 +++++++++++++++++++++
 tb/tb_alu_result_monitor.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_monitor_if.sv
// alu_result_monitor_if: ALU-side observation signals plus the transaction
// drain port of the result monitor. The master modport is the bench side,
// which drives the ALU stimulus and consumes transactions. The slave modport
// is the monitor.
interface alu_result_monitor_if #(
  parameter int DEPTH = 8
);
  // ALU observation
  logic                   op_valid;
  logic [4:0]             Operation;
  logic                   EX_Flush;
  logic                   ALU_Stall;
  logic                   BZero;
  logic                   EXC_Ov;
  logic [31:0]            Result;
  logic [31:0]            out_HI;
  logic [31:0]            out_LO;
  // transaction drain
  logic                   txn_valid;
  logic                   txn_ready;
  logic [7:0]             txn_seq;
  logic [4:0]             txn_op;
  logic [31:0]            txn_result;
  logic [31:0]            txn_hi;
  logic [31:0]            txn_lo;
  logic                   txn_bzero;
  logic                   txn_ov;
  logic                   txn_timeout;
  // status
  logic [$clog2(DEPTH):0] fifo_count;
  logic [15:0]            drop_count;
  logic [15:0]            flush_count;
  logic                   proto_err;

  modport master (
    output op_valid, Operation, EX_Flush, ALU_Stall, BZero, EXC_Ov,
           Result, out_HI, out_LO, txn_ready,
    input  txn_valid, txn_seq, txn_op, txn_result, txn_hi, txn_lo,
           txn_bzero, txn_ov, txn_timeout, fifo_count, drop_count,
           flush_count, proto_err
  );

  modport slave (
    input  op_valid, Operation, EX_Flush, ALU_Stall, BZero, EXC_Ov,
           Result, out_HI, out_LO, txn_ready,
    output txn_valid, txn_seq, txn_op, txn_result, txn_hi, txn_lo,
           txn_bzero, txn_ov, txn_timeout, fifo_count, drop_count,
           flush_count, proto_err
  );
endinterface

// File: rtl/alu_result_monitor.sv
// alu_result_monitor: waits out the ALU capture delay and any stall for each
// issued operation. It then captures Result/HI/LO/flags with a sequence tag
// into a FIFO, which a consumer drains over valid/ready.
// Optional feature: define ALU_MON_TIMEOUT_EN to bound the stall wait by
// TIMEOUT cycles. On expiry, a capture is forced with txn_timeout=1.
module alu_result_monitor #(
  parameter int DEPTH     = 8,
  parameter int CAP_DELAY = 1,
  parameter int TIMEOUT   = 64
) (
  input logic                 clock,
  input logic                 reset,
  alu_result_monitor_if.slave mon
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // elaboration-time parameter sanity
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("alu_result_monitor: DEPTH must be a power of two >= 2");
  end
  if (CAP_DELAY < 1 || CAP_DELAY > 15) begin : g_bad_delay
    $error("alu_result_monitor: CAP_DELAY must be 1..15");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("alu_result_monitor: TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_WAIT} state_e;

  typedef struct packed {
    logic [7:0]  seq;
    logic [4:0]  op;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        bzero;
    logic        ov;
`ifdef ALU_MON_TIMEOUT_EN
    logic        timeout;
`endif
  } entry_t;

  state_e      state_q, state_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic [4:0]  op_q, op_d;
  logic        capture, flush_ev, proto_ev;
`ifdef ALU_MON_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT);
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          cap_to;
`endif

  logic [CW-1:0] wr_ptr, rd_ptr, count;
  logic          valid, full, push, pop, drop;
  logic [7:0]    seq_q;
  logic [15:0]   drop_q, flush_q;
  logic          proto_q;
  entry_t        mem [DEPTH];
  entry_t        cap_e, head;

  // next-state: issue, delay countdown, stall wait, flush abort
  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    op_d     = op_q;
    capture  = 1'b0;
    flush_ev = 1'b0;
    proto_ev = 1'b0;
`ifdef ALU_MON_TIMEOUT_EN
    wcnt_d   = wcnt_q;
    cap_to   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (mon.op_valid) begin
          if (mon.EX_Flush) flush_ev = 1'b1;
          else begin
            op_d    = mon.Operation;
            dcnt_d  = 4'(CAP_DELAY - 1);
            state_d = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        proto_ev = mon.op_valid;
        if (mon.EX_Flush) begin
          flush_ev = 1'b1;
          state_d  = S_IDLE;
        end else if (dcnt_q != 4'd0) begin
          dcnt_d = dcnt_q - 4'd1;
        end else if (!mon.ALU_Stall) begin
          capture = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
`ifdef ALU_MON_TIMEOUT_EN
          // the sample cycle already counts as one stalled cycle
          wcnt_d  = WW'(1);
`endif
        end
      end
      S_WAIT: begin
        proto_ev = mon.op_valid;
        if (mon.EX_Flush) begin
          flush_ev = 1'b1;
          state_d  = S_IDLE;
        end else if (!mon.ALU_Stall) begin
          capture = 1'b1;
          state_d = S_IDLE;
        end
`ifdef ALU_MON_TIMEOUT_EN
        else if (wcnt_q == WW'(TIMEOUT - 1)) begin
          capture = 1'b1;
          cap_to  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, delay counter and latched opcode
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      op_q    <= op_d;
    end
  end

`ifdef ALU_MON_TIMEOUT_EN
  // consecutive stalled-cycle counter for the forced capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) wcnt_q <= '0;
    else        wcnt_q <= wcnt_d;
  end
`endif

  // capture entry: ALU values as they stand in the capture cycle
  always_comb begin
    cap_e        = '0;
    cap_e.seq    = seq_q;
    cap_e.op     = op_q;
    cap_e.result = mon.Result;
    cap_e.hi     = mon.out_HI;
    cap_e.lo     = mon.out_LO;
    cap_e.bzero  = mon.BZero;
    cap_e.ov     = mon.EXC_Ov;
`ifdef ALU_MON_TIMEOUT_EN
    cap_e.timeout = cap_to;
`endif
  end

  // a pop in the same cycle frees a slot, so a full FIFO still accepts
  assign count = wr_ptr - rd_ptr;
  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = valid && mon.txn_ready;
  assign push  = capture && (!full || pop);
  assign drop  = capture && full && !pop;

  // FIFO storage, no reset needed since reads are gated by valid
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cap_e;
  end

  // pointers, sequence tag and status counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
      flush_q <= '0;
      proto_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CW'(1);
      if (pop)  rd_ptr <= rd_ptr + CW'(1);
      // seq advances on drops too so the consumer can see the gap
      if (capture) seq_q <= seq_q + 8'd1;
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (flush_ev && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
      if (proto_ev) proto_q <= 1'b1;
    end
  end

  assign head = valid ? mem[rd_ptr[AW-1:0]] : '0;

  assign mon.txn_valid   = valid;
  assign mon.txn_seq     = head.seq;
  assign mon.txn_op      = head.op;
  assign mon.txn_result  = head.result;
  assign mon.txn_hi      = head.hi;
  assign mon.txn_lo      = head.lo;
  assign mon.txn_bzero   = head.bzero;
  assign mon.txn_ov      = head.ov;
`ifdef ALU_MON_TIMEOUT_EN
  assign mon.txn_timeout = head.timeout;
`else
  assign mon.txn_timeout = 1'b0;
`endif
  assign mon.fifo_count  = count;
  assign mon.drop_count  = drop_q;
  assign mon.flush_count = flush_q;
  assign mon.proto_err   = proto_q;
endmodule

// File: tb/tb_alu_result_monitor.sv
// tb_alu_result_monitor: directed sequence with randomized ALU data, checked
// against a queue-based reference of the expected transaction stream.
module tb_alu_result_monitor;
  localparam int DEPTH = 8, CAP_DELAY = 1, TIMEOUT = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  alu_result_monitor_if #(.DEPTH(DEPTH)) bus ();
  alu_result_monitor #(.DEPTH(DEPTH), .CAP_DELAY(CAP_DELAY), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .mon(bus)
  );

  typedef struct {
    logic [7:0]  seq;
    logic [4:0]  op;
    logic [31:0] r, hi, lo;
    logic        bz, ov, to;
  } exp_t;

  exp_t exp_q[$];
  int   m_seq, m_drop, m_flush;
  bit   m_proto, cap_ready;
  int   passed = 0, total = 0;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    exp_q.delete(); m_seq = 0; m_drop = 0; m_flush = 0; m_proto = 0;
  endtask

  // one capture as the rules define it: pop frees a slot, full drops, seq always advances
  task automatic model_capture(input logic [4:0] op, input bit to);
    exp_t e;
    e.seq = 8'(m_seq); e.op = op; e.r = bus.Result; e.hi = bus.out_HI;
    e.lo = bus.out_LO; e.bz = bus.BZero; e.ov = bus.EXC_Ov; e.to = to;
    if (cap_ready && exp_q.size() > 0) exp_q.delete(0);
    if (exp_q.size() >= DEPTH) m_drop++;
    else exp_q.push_back(e);
    m_seq = (m_seq + 1) % 256;
  endtask

  task automatic idle_inputs();
    bus.op_valid = 0; bus.Operation = 0; bus.EX_Flush = 0; bus.ALU_Stall = 0;
    bus.BZero = 0; bus.EXC_Ov = 0; bus.Result = 0; bus.out_HI = 0; bus.out_LO = 0;
    bus.txn_ready = 0;
  endtask

  task automatic chk_stat(input string tag);
    chk({tag, " fifo_count"}, bus.fifo_count, exp_q.size());
    chk({tag, " txn_valid"}, bus.txn_valid, exp_q.size() != 0);
    chk({tag, " drop_count"}, bus.drop_count, m_drop);
    chk({tag, " flush_count"}, bus.flush_count, m_flush);
    chk({tag, " proto_err"}, bus.proto_err, m_proto);
  endtask

  // issue, hold stall for 'stall' cycles (optionally re-pulsing op_valid), then capture
  task automatic do_op(input logic [4:0] op, input int stall, input int proto_at,
                       input logic [31:0] r, input logic [31:0] hi, input logic [31:0] lo,
                       input bit bz, input bit ov);
    bus.Operation = op; bus.op_valid = 1; tick();
    bus.op_valid = 0; bus.Operation = 5'($urandom);
    repeat (CAP_DELAY - 1) tick();
    for (int i = 0; i < stall; i++) begin
      bus.ALU_Stall = 1; bus.Result = $urandom; bus.out_HI = $urandom; bus.out_LO = $urandom;
      bus.op_valid = (i == proto_at);
      if (i == proto_at) m_proto = 1;
      tick();
    end
    bus.op_valid = 0; bus.ALU_Stall = 0;
    bus.Result = r; bus.out_HI = hi; bus.out_LO = lo; bus.BZero = bz; bus.EXC_Ov = ov;
    bus.txn_ready = cap_ready;
    model_capture(op, 1'b0);
    tick();
    bus.txn_ready = 0;
  endtask

  task automatic rand_op(input int max_stall);
    do_op(5'($urandom), $urandom_range(0, max_stall), -1, $urandom, $urandom, $urandom,
          1'($urandom), 1'($urandom));
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    e = exp_q[0];
    chk({tag, " head valid"}, bus.txn_valid, 1);
    chk({tag, " head seq"}, bus.txn_seq, e.seq);
    chk({tag, " head result"}, bus.txn_result, e.r);
    chk({tag, " head hi/lo"}, {bus.txn_hi, bus.txn_lo}, {e.hi, e.lo});
    chk({tag, " head op/flags"}, {bus.txn_op, bus.txn_bzero, bus.txn_ov, bus.txn_timeout},
        {e.op, e.bz, e.ov, e.to});
    bus.txn_ready = 1; tick(); bus.txn_ready = 0;
    exp_q.delete(0);
  endtask

  task automatic do_reset();
    reset = 0; idle_inputs(); model_clear();
    tick(); tick();
    reset = 1; tick();
  endtask

  initial begin
    idle_inputs(); model_clear(); cap_ready = 0;
    repeat (3) @(posedge clock);
    #1;
    chk_stat("reset");
    chk("reset txn_seq", bus.txn_seq, 0);
    chk("reset txn_result", bus.txn_result, 0);
    reset = 1; tick();

    // add op, CAP_DELAY=1: visible two cycles after issue
    do_op(5'h04, 0, -1, 32'h5, $urandom, $urandom, 0, 0);
    chk("t1 txn_valid", bus.txn_valid, 1);
    chk("t1 txn_seq", bus.txn_seq, 0);
    chk("t1 txn_result", bus.txn_result, 32'h5);
    chk("t1 fifo_count", bus.fifo_count, 1);
    pop_check("t1");
    chk_stat("t1 drained");

    // multiply stalled 10 cycles, extra op_valid in the stall
    do_op(5'h18, 10, 3, $urandom, 32'h1, 32'hFFFF_FFFE, 1'($urandom), 0);
    chk("t2 proto_err", bus.proto_err, 1);
    repeat (3) tick();
    chk_stat("t2 one entry");
    chk("t2 txn_hi", bus.txn_hi, 32'h1);
    chk("t2 txn_lo", bus.txn_lo, 32'hFFFF_FFFE);
    pop_check("t2");

    // mixed random traffic with interleaved drains
    for (int k = 0; k < 8; k++) begin
      rand_op(4);
      if ($urandom_range(0, 1) == 1 && exp_q.size() > 0) pop_check("mix");
    end
    chk_stat("mix");
    while (exp_q.size() > 0) pop_check("mix drain");
    chk_stat("mix drained");

    // overflow: 9 ops into 8 slots, then a capture with a simultaneous pop
    do_reset();
    for (int k = 0; k < 9; k++) rand_op(2);
    chk("t3 fifo_count", bus.fifo_count, 8);
    chk("t3 drop_count", bus.drop_count, 1);
    chk_stat("t3 full");
    cap_ready = 1; rand_op(0); cap_ready = 0;
    chk_stat("t3 full push+pop");
    while (exp_q.size() > 0) pop_check("t3 drain");
    chk_stat("t3 drained");

    // flush in DELAY, flush with issue in IDLE, flush in WAIT with op_valid
    do_reset();
    bus.Operation = 5'h04; bus.op_valid = 1; tick();
    bus.op_valid = 0; bus.EX_Flush = 1; tick();
    bus.EX_Flush = 0; m_flush++;
    repeat (3) tick();
    chk_stat("t4 delay flush");
    bus.op_valid = 1; bus.EX_Flush = 1; tick();
    bus.op_valid = 0; bus.EX_Flush = 0; m_flush++;
    tick();
    chk_stat("t4 idle flush");
    bus.op_valid = 1; tick();
    bus.op_valid = 0; bus.ALU_Stall = 1;
    repeat (4) tick();
    bus.EX_Flush = 1; bus.op_valid = 1; m_proto = 1; tick();
    bus.EX_Flush = 0; bus.op_valid = 0; bus.ALU_Stall = 0; m_flush++;
    repeat (3) tick();
    chk_stat("t4 wait flush");
    rand_op(1);
    chk("t4 next seq", bus.txn_seq, 0);
    pop_check("t4");

    // ALU_Stall stuck high
    bus.Operation = 5'h1A; bus.op_valid = 1; tick();
    bus.op_valid = 0; bus.Operation = 5'h00;
    for (int i = 1; i <= TIMEOUT; i++) begin
      bus.ALU_Stall = 1; bus.Result = $urandom; bus.out_HI = $urandom; bus.out_LO = $urandom;
`ifdef ALU_MON_TIMEOUT_EN
      if (i == TIMEOUT) begin
        chk("t5 before timeout", bus.fifo_count, 0);
        model_capture(5'h1A, 1'b1);
      end
`endif
      tick();
    end
`ifdef ALU_MON_TIMEOUT_EN
    bus.ALU_Stall = 0;
    chk_stat("t5 timeout entry");
    pop_check("t5");
`else
    repeat (16) tick();
    chk_stat("t5 no entry");
    bus.ALU_Stall = 0; bus.Result = $urandom;
    model_capture(5'h1A, 1'b0);
    tick();
    pop_check("t5 release");
`endif

    // async reset mid-WAIT with 3 entries queued
    for (int k = 0; k < 3; k++) rand_op(1);
    bus.op_valid = 1; bus.Operation = 5'h18; tick();
    bus.op_valid = 0; bus.ALU_Stall = 1; tick();
    bus.op_valid = 1; tick();
    bus.op_valid = 0; tick();
    chk("t6 pre-reset count", bus.fifo_count, 3);
    chk("t6 pre-reset proto", bus.proto_err, 1);
    #2 reset = 0; model_clear();
    #1 chk_stat("t6 async reset");
    chk("t6 txn_seq", bus.txn_seq, 0);
    idle_inputs(); tick();
    reset = 1; tick();
    rand_op(0);
    chk("t6 seq restart", bus.txn_seq, 0);
    pop_check("t6");
    chk_stat("end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
